// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
package icache_pkg;

  // Default geometry: 64 lines, one 32-bit instruction per line.
  localparam int DEFAULT_INDEX_WIDTH = 6;

  // Controller states. IDLE looks up, MISS waits on MemCtrl, RESP is the
  // single cycle in which a response is presented to the fetcher.
  typedef enum logic [1:0] {
    ICACHE_IDLE = 2'd0,
    ICACHE_MISS = 2'd1,
    ICACHE_RESP = 2'd2
  } icache_state_e;

  // Word-aligned byte address sent to MemCtrl.
  function automatic logic [31:0] word_addr(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data storage for the instruction cache: asynchronous read by
// index, one synchronous write port, synchronous clear of every valid bit.
module icache_line_store #(
  parameter int INDEX_WIDTH = 6,
  parameter int TAG_WIDTH   = 24
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [INDEX_WIDTH-1:0] i_rd_index,
  output logic                   o_rd_valid,
  output logic [TAG_WIDTH-1:0]   o_rd_tag,
  output logic [31:0]            o_rd_data,
  input  logic                   i_wr_en,
  input  logic [INDEX_WIDTH-1:0] i_wr_index,
  input  logic [TAG_WIDTH-1:0]   i_wr_tag,
  input  logic [31:0]            i_wr_data
);

  localparam int LINES = 1 << INDEX_WIDTH;

  logic [LINES-1:0]     w_valid;
  logic [TAG_WIDTH-1:0] r_tag  [LINES];
  logic [31:0]          r_data [LINES];

  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_valid
      logic r_v;
      // Per-line valid flop: cleared on reset, set when its line is filled.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_v <= 1'b0;
        end else if (i_wr_en && (i_wr_index == INDEX_WIDTH'(gi))) begin
          r_v <= 1'b1;
        end
      end
      assign w_valid[gi] = r_v;
    end
  endgenerate

  // Tag and instruction arrays; contents are meaningless until valid is set,
  // so they carry no reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_index]  <= i_wr_tag;
      r_data[i_wr_index] <= i_wr_data;
    end
  end

  assign o_rd_valid = w_valid[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_data  = r_data[i_rd_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache sitting between the fetcher and the MemCtrl
// fetch port. Hits answer one cycle after acceptance; misses request the word
// from MemCtrl, fill the line and then answer. Only one request is ever in
// flight, so the fill write and the lookup read never contend.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        fetch_req,
  input  logic [31:0] fetch_pc,
  input  logic        flush,
  output logic        out_valid,
  output logic [31:0] out_ins,
  output logic        mem_need,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_ins
);

  localparam int TAG_WIDTH = 32 - INDEX_WIDTH - 2;

  icache_state_e r_state;
  icache_state_e w_state_next;

  logic [31:2]  r_pc;
  logic         r_discard;
  logic         r_out_valid;
  logic [31:0]  r_out_ins;
  logic         r_mem_need;
  logic [31:0]  r_mem_addr;

  logic [31:2]  w_pc_next;
  logic         w_discard_next;
  logic         w_out_valid_next;
  logic [31:0]  w_out_ins_next;
  logic         w_mem_need_next;
  logic [31:0]  w_mem_addr_next;

  logic                   w_rd_valid;
  logic [TAG_WIDTH-1:0]   w_rd_tag;
  logic [31:0]            w_rd_data;
  logic                   w_hit;
  logic                   w_accept;
  logic                   w_wr_en;
  logic                   w_unused_pc_lsbs;

  // Byte offset within the word plays no part in the lookup.
  assign w_unused_pc_lsbs = ^fetch_pc[1:0];

  assign w_accept = (r_state == ICACHE_IDLE) && fetch_req && !flush;
  assign w_hit    = w_rd_valid && (w_rd_tag == fetch_pc[31:INDEX_WIDTH+2]);
  // Fill only when MemCtrl delivers during a miss and the pipeline is live;
  // stray mem_ready pulses in other states never touch the array.
  assign w_wr_en  = rdy_in && (r_state == ICACHE_MISS) && mem_ready;

  icache_line_store #(
    .INDEX_WIDTH(INDEX_WIDTH),
    .TAG_WIDTH  (TAG_WIDTH)
  ) u_line_store (
    .i_clk     (clk_in),
    .i_rst     (rst_in),
    .i_rd_index(fetch_pc[INDEX_WIDTH+1:2]),
    .o_rd_valid(w_rd_valid),
    .o_rd_tag  (w_rd_tag),
    .o_rd_data (w_rd_data),
    .i_wr_en   (w_wr_en),
    .i_wr_index(r_pc[INDEX_WIDTH+1:2]),
    .i_wr_tag  (r_pc[31:INDEX_WIDTH+2]),
    .i_wr_data (mem_ins)
  );

  // State register; rdy_in low freezes the controller.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= ICACHE_IDLE;
    end else if (rdy_in) begin
      r_state <= w_state_next;
    end
  end

  // Next-state selection.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ICACHE_IDLE: if (w_accept) w_state_next = w_hit ? ICACHE_RESP : ICACHE_MISS;
      ICACHE_MISS: if (mem_ready) w_state_next = ICACHE_RESP;
      ICACHE_RESP: w_state_next = ICACHE_IDLE;
      default:     w_state_next = ICACHE_IDLE;
    endcase
  end

  // Next values for the registered outputs, pc latch and discard flag.
  always_comb begin
    w_pc_next        = r_pc;
    w_discard_next   = r_discard;
    w_out_valid_next = 1'b0;
    w_out_ins_next   = r_out_ins;
    w_mem_need_next  = r_mem_need;
    w_mem_addr_next  = r_mem_addr;
    case (r_state)
      ICACHE_IDLE: begin
        if (w_accept) begin
          w_pc_next = fetch_pc[31:2];
          if (w_hit) begin
            w_out_valid_next = 1'b1;
            w_out_ins_next   = w_rd_data;
          end else begin
            w_mem_need_next = 1'b1;
            w_mem_addr_next = word_addr(fetch_pc);
          end
        end
      end
      ICACHE_MISS: begin
        // The MemCtrl transfer cannot be aborted; a flush only hides its result.
        if (flush) w_discard_next = 1'b1;
        if (mem_ready) begin
          w_mem_need_next = 1'b0;
          if (!(r_discard || flush)) begin
            w_out_valid_next = 1'b1;
            w_out_ins_next   = mem_ins;
          end
        end
      end
      ICACHE_RESP: begin
        w_discard_next = 1'b0;
      end
      default: begin
        w_discard_next = 1'b0;
      end
    endcase
  end

  // Output and datapath registers, frozen together with the state.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_pc        <= '0;
      r_discard   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_ins   <= '0;
      r_mem_need  <= 1'b0;
      r_mem_addr  <= '0;
    end else if (rdy_in) begin
      r_pc        <= w_pc_next;
      r_discard   <= w_discard_next;
      r_out_valid <= w_out_valid_next;
      r_out_ins   <= w_out_ins_next;
      r_mem_need  <= w_mem_need_next;
      r_mem_addr  <= w_mem_addr_next;
    end
  end

  assign out_valid = r_out_valid;
  assign out_ins   = r_out_ins;
  assign mem_need  = r_mem_need;
  assign mem_addr  = r_mem_addr;

endmodule
